// File: rtl/tmr_pkg.sv
// ============================================================================
// tmr_pkg: shared encodings, register bit indices and helpers for the timer
//          compare-match output stage.                           Rev 1.0
// ============================================================================
`default_nettype none

package tmr_pkg;

  typedef enum logic [1:0] {
    OS_NOP    = 2'b00,
    OS_LOW    = 2'b01,
    OS_HIGH   = 2'b10,
    OS_TOGGLE = 2'b11
  } os_e;

  typedef enum logic [1:0] {
    CCLR_NONE = 2'b00,
    CCLR_A    = 2'b01,
    CCLR_B    = 2'b10,
    CCLR_TMRI = 2'b11
  } cclr_e;

  localparam int TCR_CMIEB   = 7;
  localparam int TCR_CMIEA   = 6;
  localparam int TCR_OVIE    = 5;
  localparam int TCR_CCLR_HI = 4;
  localparam int TCR_CCLR_LO = 3;

  localparam int TCSR_CMFB   = 7;
  localparam int TCSR_CMFA   = 6;
  localparam int TCSR_OVF    = 5;
  localparam int TCSR_ADTE   = 4;
  localparam int TCSR_OSB_HI = 3;
  localparam int TCSR_OSB_LO = 2;
  localparam int TCSR_OSA_HI = 1;
  localparam int TCSR_OSA_LO = 0;

  // Reserved TCR bits [2:0] never store a 1.
  localparam logic [7:0] TCR_WMASK = 8'hF8;

  typedef struct packed {
    logic flag;
    logic arm;
  } flag_st_t;

  // Read-then-write-0 clear handshake; a set event always beats a clear.
  function automatic flag_st_t flag_next(logic flag_q, logic arm_q, logic set,
                                         logic rd, logic wr, logic wbit);
    flag_st_t r;
    logic     armed;
    logic     clr;
    armed  = arm_q | (rd & flag_q);
    clr    = wr & ~wbit & armed;
    r.flag = set | (flag_q & ~clr);
    r.arm  = armed & ~clr;
    return r;
  endfunction

  // Coinciding A/B actions resolve toggle > drive 1 > drive 0.
  function automatic logic resolve_tmo(logic cur, os_e a, os_e b);
    if (a == OS_TOGGLE || b == OS_TOGGLE) return ~cur;
    if (a == OS_HIGH || b == OS_HIGH)     return 1'b1;
    if (a == OS_LOW || b == OS_LOW)       return 1'b0;
    return cur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmr_match_output_if.sv
// ============================================================================
// tmr_match_output_if: CPU register bus of one timer channel (TCR/TCSR).
//                                                                 Rev 1.0
// ============================================================================
`default_nettype none

interface tmr_match_output_if #(
  parameter int BIT_WIDTH = 8
);
  logic                 tcr_wr;
  logic                 tcsr_wr;
  logic                 tcsr_rd;
  logic [BIT_WIDTH-1:0] wdata;
  logic [BIT_WIDTH-1:0] tcr_rdata;
  logic [BIT_WIDTH-1:0] tcsr_rdata;

  modport master (
    output tcr_wr, tcsr_wr, tcsr_rd, wdata,
    input  tcr_rdata, tcsr_rdata
  );

  modport slave (
    input  tcr_wr, tcsr_wr, tcsr_rd, wdata,
    output tcr_rdata, tcsr_rdata
  );
endinterface

`default_nettype wire

// File: rtl/tmr_sync_edge.sv
// ============================================================================
// tmr_sync_edge: multi-flop synchronizer with rising-edge detector.
//                                                                 Rev 1.0
// ============================================================================
`default_nettype none

module tmr_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

`default_nettype wire

// File: rtl/tmr_match_output.sv
// ============================================================================
// tmr_match_output: per-channel compare-match/overflow event stage with
//                   TCR/TCSR, TMO pin, counter clear, IRQs and A/D trigger. Rev 1.0
// ============================================================================
`default_nettype none

module tmr_match_output
  import tmr_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      match_a,
  input  logic                      match_b,
  input  logic                      ovf,
  input  logic                      tmri,
  tmr_match_output_if.slave         bus,
  output logic                      counter_clear,
  output logic                      tmo,
  output logic                      irq_cmia,
  output logic                      irq_cmib,
  output logic                      irq_ovi,
  output logic                      adc_trig
);

  localparam int FLG_OVF = 0;
  localparam int FLG_A   = 1;
  localparam int FLG_B   = 2;

  localparam logic [BIT_WIDTH-1:0] TCR_WR_MASK = BIT_WIDTH'(TCR_WMASK);

  logic [BIT_WIDTH-1:0] tcr_q, tcr_d;
  logic [4:0]           ctl_q, ctl_d;
  logic [2:0]           flag_q, flag_d;
  logic [2:0]           arm_q, arm_d;
  logic [2:0]           prev_q;
  logic                 tmo_q, tmo_d;
  logic                 clear_q, clear_d;
  logic                 adc_q, adc_d;

  logic [2:0]           lvl;
  logic [2:0]           ev;
  logic                 tmri_rise;
  os_e                  act_a;
  os_e                  act_b;

  tmr_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tmri_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (tmri),
    .rise_o  (tmri_rise)
  );

  assign lvl = {match_b, match_a, ovf};
  assign ev  = lvl & ~prev_q;

  for (genvar i = 0; i < 3; i++) begin : g_flag
    flag_st_t nxt;
    assign nxt = flag_next(flag_q[i], arm_q[i], ev[i], bus.tcsr_rd,
                           bus.tcsr_wr, bus.wdata[TCSR_OVF+i]);
    assign flag_d[i] = nxt.flag;
    assign arm_d[i]  = nxt.arm;
  end

  always_comb begin
    tcr_d   = tcr_q;
    ctl_d   = ctl_q;
    clear_d = 1'b0;
    act_a   = ev[FLG_A] ? os_e'(ctl_q[TCSR_OSA_HI:TCSR_OSA_LO]) : OS_NOP;
    act_b   = ev[FLG_B] ? os_e'(ctl_q[TCSR_OSB_HI:TCSR_OSB_LO]) : OS_NOP;
    tmo_d   = resolve_tmo(tmo_q, act_a, act_b);
    adc_d   = ev[FLG_A] & ctl_q[TCSR_ADTE];

    // Clear source uses the CCLR value held before this edge.
    case (cclr_e'(tcr_q[TCR_CCLR_HI:TCR_CCLR_LO]))
      CCLR_A:    clear_d = ev[FLG_A];
      CCLR_B:    clear_d = ev[FLG_B];
      CCLR_TMRI: clear_d = tmri_rise;
      default:   clear_d = 1'b0;
    endcase

    if (bus.tcr_wr) begin
      tcr_d = bus.wdata & TCR_WR_MASK;
    end
    if (bus.tcsr_wr) begin
      ctl_d = bus.wdata[TCSR_ADTE:TCSR_OSA_LO];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcr_q   <= '0;
      ctl_q   <= '0;
      flag_q  <= '0;
      arm_q   <= '0;
      prev_q  <= '0;
      tmo_q   <= 1'b0;
      clear_q <= 1'b0;
      adc_q   <= 1'b0;
    end else begin
      tcr_q   <= tcr_d;
      ctl_q   <= ctl_d;
      flag_q  <= flag_d;
      arm_q   <= arm_d;
      prev_q  <= lvl;
      tmo_q   <= tmo_d;
      clear_q <= clear_d;
      adc_q   <= adc_d;
    end
  end

  assign bus.tcr_rdata  = tcr_q;
  assign bus.tcsr_rdata = BIT_WIDTH'({flag_q, ctl_q});

  assign counter_clear = clear_q;
  assign tmo           = tmo_q;
  assign adc_trig      = adc_q;
  assign irq_cmia      = flag_q[FLG_A]   & tcr_q[TCR_CMIEA];
  assign irq_cmib      = flag_q[FLG_B]   & tcr_q[TCR_CMIEB];
  assign irq_ovi       = flag_q[FLG_OVF] & tcr_q[TCR_OVIE];

endmodule

`default_nettype wire

// File: tb/tb_tmr_match_output.sv
// ============================================================================
// tb_tmr_match_output: directed plus randomized bench for tmr_match_output
//                      against a behavioural channel model.        Rev 1.0
// ============================================================================
`default_nettype none

module tb_tmr_match_output;

  localparam int BW = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic match_a, match_b, ovf, tmri;
  logic counter_clear, tmo, irq_cmia, irq_cmib, irq_ovi, adc_trig;

  always #5 clk = ~clk;

  tmr_match_output_if #(.BIT_WIDTH(BW)) bus ();

  tmr_match_output #(
    .BIT_WIDTH   (BW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .match_a       (match_a),
    .match_b       (match_b),
    .ovf           (ovf),
    .tmri          (tmri),
    .bus           (bus),
    .counter_clear (counter_clear),
    .tmo           (tmo),
    .irq_cmia      (irq_cmia),
    .irq_cmib      (irq_cmib),
    .irq_ovi       (irq_ovi),
    .adc_trig      (adc_trig)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state; channel index 0 = compare A, 1 = compare B, 2 = overflow.
  bit [7:0] m_tcr;
  bit [4:0] m_ctl;
  bit       m_flag [3];
  bit       m_arm  [3];
  bit       m_prev [3];
  bit       m_tmo, m_cc, m_adc;
  bit       m_hist [$];

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tcr = '0;
    m_ctl = '0;
    m_tmo = 0;
    m_cc  = 0;
    m_adc = 0;
    for (int i = 0; i < 3; i++) begin
      m_flag[i] = 0;
      m_arm[i]  = 0;
      m_prev[i] = 0;
    end
    m_hist.delete();
  endtask

  function automatic bit hist_at(int idx);
    if (idx < 0) return 1'b0;
    return m_hist[idx];
  endfunction

  task automatic model_edge(bit ma, bit mb, bit ov, bit tm, bit rd, bit wt,
                            bit ws, bit [7:0] wd);
    bit lvl [3];
    bit ev  [3];
    int bitpos [3];
    bit [1:0] act_a, act_b;
    bit rise;
    int n;
    lvl    = '{ma, mb, ov};
    bitpos = '{6, 7, 5};
    for (int i = 0; i < 3; i++) ev[i] = lvl[i] && !m_prev[i];
    for (int i = 0; i < 3; i++) begin
      bit armed;
      bit clr;
      armed = m_arm[i] || (rd && m_flag[i]);
      clr   = ws && !wd[bitpos[i]] && armed;
      if (ev[i]) begin
        m_flag[i] = 1;
        m_arm[i]  = clr ? 1'b0 : armed;
      end else if (clr) begin
        m_flag[i] = 0;
        m_arm[i]  = 0;
      end else begin
        m_arm[i]  = armed;
      end
    end
    act_a = ev[0] ? m_ctl[1:0] : 2'd0;
    act_b = ev[1] ? m_ctl[3:2] : 2'd0;
    if (act_a == 3 || act_b == 3)      m_tmo = !m_tmo;
    else if (act_a == 2 || act_b == 2) m_tmo = 1;
    else if (act_a == 1 || act_b == 1) m_tmo = 0;
    // The pin sample taken SS edges ago becomes a detected rise one edge before the pulse.
    n    = m_hist.size();
    rise = hist_at(n - SS) && !hist_at(n - SS - 1);
    case (m_tcr[4:3])
      2'd1:    m_cc = ev[0];
      2'd2:    m_cc = ev[1];
      2'd3:    m_cc = rise;
      default: m_cc = 0;
    endcase
    m_adc = ev[0] && m_ctl[4];
    m_hist.push_back(tm);
    if (wt) m_tcr = wd & 8'hF8;
    if (ws) m_ctl = wd[4:0];
    for (int i = 0; i < 3; i++) m_prev[i] = lvl[i];
  endtask

  task automatic compare_all();
    check_value("tmo",       tmo,            m_tmo);
    check_value("clear",     counter_clear,  m_cc);
    check_value("adc_trig",  adc_trig,       m_adc);
    check_value("tcr_rd",    bus.tcr_rdata,  m_tcr);
    check_value("tcsr_rd",   bus.tcsr_rdata, {m_flag[1], m_flag[0], m_flag[2], m_ctl});
    check_value("irq_cmia",  irq_cmia,       m_flag[0] & m_tcr[6]);
    check_value("irq_cmib",  irq_cmib,       m_flag[1] & m_tcr[7]);
    check_value("irq_ovi",   irq_ovi,        m_flag[2] & m_tcr[5]);
  endtask

  task automatic tick();
    bit ma = match_a, mb = match_b, ov = ovf, tm = tmri;
    bit rd = bus.tcsr_rd, wt = bus.tcr_wr, ws = bus.tcsr_wr;
    bit [7:0] wd = bus.wdata;
    @(posedge clk);
    model_edge(ma, mb, ov, tm, rd, wt, ws, wd);
    #1;
    compare_all();
  endtask

  task automatic write_tcsr(input bit [7:0] d);
    bus.tcsr_wr = 1;
    bus.wdata   = d;
    tick();
    bus.tcsr_wr = 0;
  endtask

  task automatic write_tcr(input bit [7:0] d);
    bus.tcr_wr = 1;
    bus.wdata  = d;
    tick();
    bus.tcr_wr = 0;
  endtask

  task automatic read_tcsr();
    bus.tcsr_rd = 1;
    tick();
    bus.tcsr_rd = 0;
  endtask

  task automatic do_reset();
    rst_n       = 0;
    match_a     = 0;
    match_b     = 0;
    ovf         = 0;
    tmri        = 0;
    bus.tcr_wr  = 0;
    bus.tcsr_wr = 0;
    bus.tcsr_rd = 0;
    bus.wdata   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    repeat (5) tick();
    check_value("rst_tmo",   tmo, 0);
    check_value("rst_clear", counter_clear, 0);
    check_value("rst_irq",   {irq_cmia, irq_cmib, irq_ovi, adc_trig}, 0);
    check_value("rst_tcsr",  bus.tcsr_rdata, 8'h00);
    check_value("rst_tcr",   bus.tcr_rdata, 8'h00);

    // Toggle on A: three pulses of 2 high / 3 low
    write_tcsr(8'h03);
    for (int k = 0; k < 3; k++) begin
      match_a = 1;
      tick();
      check_value("os_toggle_tmo", tmo, (k + 1) % 2);
      check_value("os_toggle_cmfa", bus.tcsr_rdata[6], 1);
      tick();
      match_a = 0;
      repeat (3) tick();
    end

    // Coinciding A/B events
    write_tcsr(8'h01);
    match_a = 1;
    tick();
    match_a = 0;
    tick();
    check_value("preset_tmo0", tmo, 0);
    write_tcsr(8'h09);
    match_a = 1; match_b = 1;
    tick();
    check_value("high_beats_low", tmo, 1);
    match_a = 0; match_b = 0;
    tick();
    write_tcsr(8'h0D);
    match_a = 1; match_b = 1;
    tick();
    check_value("toggle_beats_low", tmo, 0);
    match_a = 0; match_b = 0;
    tick();

    // Flag clear handshake
    write_tcsr(8'hBF);
    check_value("unarmed_wr_keeps", bus.tcsr_rdata[6], 1);
    read_tcsr();
    write_tcsr(8'hBF);
    check_value("armed_wr_clears", bus.tcsr_rdata[6], 0);
    check_value("cmfb_untouched", bus.tcsr_rdata[7], 1);
    match_a = 1;
    tick();
    match_a = 0;
    tick();
    read_tcsr();
    match_a     = 1;
    bus.tcsr_wr = 1;
    bus.wdata   = 8'hBF;
    tick();
    check_value("set_beats_clear", bus.tcsr_rdata[6], 1);
    bus.tcsr_wr = 0;
    match_a     = 0;
    tick();

    // Counter clear sources
    write_tcr(8'h08);
    match_a = 1;
    tick();
    check_value("cclr_a_pulse", counter_clear, 1);
    match_a = 0;
    tick();
    check_value("cclr_a_width", counter_clear, 0);
    write_tcr(8'h18);
    #2 tmri = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_value($sformatf("cclr_tmri_c%0d", k), counter_clear, (k == SS + 1) ? 1 : 0);
    end
    write_tcr(8'h00);
    tmri = 0;
    repeat (3) tick();
    tmri = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_value("cclr_none", counter_clear, 0);
    end
    tmri = 0;
    tick();

    // A/D trigger, interrupt, then asynchronous reset mid-pulse
    write_tcr(8'h40);
    write_tcsr(8'h10);
    match_a = 1;
    tick();
    check_value("adc_pulse", adc_trig, 1);
    check_value("irq_cmia_set", irq_cmia, 1);
    #2 rst_n = 0;
    #1;
    check_value("async_rst_outs",
                {tmo, counter_clear, irq_cmia, irq_cmib, irq_ovi, adc_trig}, 0);
    do_reset();
    tick();
    check_value("post_rst_tcsr", bus.tcsr_rdata, 8'h00);
    check_value("post_rst_tcr",  bus.tcr_rdata, 8'h00);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) match_a = ~match_a;
      if ($urandom_range(0, 2) == 0) match_b = ~match_b;
      if ($urandom_range(0, 3) == 0) ovf     = ~ovf;
      if ($urandom_range(0, 3) == 0) tmri    = ~tmri;
      bus.tcsr_rd = ($urandom_range(0, 3) == 0);
      bus.tcsr_wr = ($urandom_range(0, 5) == 0);
      bus.tcr_wr  = ($urandom_range(0, 9) == 0);
      bus.wdata   = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
